// File: rtl/aes_inport.sv
// Byte-serial input port for an AES core: gathers 16 bytes into a 128-bit block,
// then hands it to the core as a non-interruptible burst of four 32-bit words.
module aes_inport (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_key,
  input  logic        core_ready,
  output logic [31:0] pass_data,
  output logic        key_en,
  output logic        text_en,
  output logic        in_busy,
  output logic        in_ovr
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    FULL    = 2'd1,
    SEND    = 2'd2
  } state_t;

  state_t         state;
  state_t         state_next;
  logic           s1;
  logic           s2;
  logic           s3;
  logic           byte_ev;
  logic [3:0]     byte_count;
  logic [127:0]   buffer;
  logic           key_lat;
  logic [1:0]     word_idx;

  // in_valid is asynchronous; s3 remembers the previous synchronized level so each
  // rising edge of the strobe yields exactly one byte event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= in_valid;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign byte_ev = s2 & ~s3;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= COLLECT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      COLLECT: if (byte_ev && byte_count == 4'd15) state_next = FULL;
      FULL:    if (core_ready) state_next = SEND;
      SEND:    if (word_idx == 2'd3) state_next = COLLECT;
      default: state_next = COLLECT;
    endcase
  end

  // Byte 0 lands in the top byte of the buffer; word 0 of the burst is the top word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_count <= 4'd0;
      buffer     <= 128'd0;
      key_lat    <= 1'b0;
      word_idx   <= 2'd0;
      pass_data  <= 32'd0;
      key_en     <= 1'b0;
      text_en    <= 1'b0;
      in_busy    <= 1'b0;
      in_ovr     <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          key_en  <= 1'b0;
          text_en <= 1'b0;
          if (byte_ev) begin
            buffer[{~byte_count, 3'b000} +: 8] <= in_data;
            byte_count <= byte_count + 4'd1;
            if (byte_count == 4'd0) begin
              key_lat <= in_key;
              in_ovr  <= 1'b0;
            end
            if (byte_count == 4'd15) begin
              in_busy <= 1'b1;
            end
          end
        end
        FULL: begin
          if (byte_ev) begin
            in_ovr <= 1'b1;
          end
          if (core_ready) begin
            pass_data <= buffer[127:96];
            key_en    <= key_lat;
            text_en   <= ~key_lat;
            word_idx  <= 2'd1;
          end
        end
        SEND: begin
          // Once started, the burst ignores core_ready and runs to word 3.
          if (byte_ev) begin
            in_ovr <= 1'b1;
          end
          pass_data <= buffer[{~word_idx, 5'b00000} +: 32];
          word_idx  <= word_idx + 2'd1;
          if (word_idx == 2'd3) begin
            in_busy <= 1'b0;
          end
        end
        default: begin
          key_en  <= 1'b0;
          text_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inport.sv
// Scoreboard bench for aes_inport: expected burst words are queued when a block is
// driven and popped by a monitor whenever the DUT marks a word on pass_data.
module tb_aes_inport;

  logic        clk;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_key;
  logic        core_ready;
  logic [31:0] pass_data;
  logic        key_en;
  logic        text_en;
  logic        in_busy;
  logic        in_ovr;

  typedef struct {
    logic [31:0] data;
    logic        key;
    logic        last;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  logic expect_cont = 1'b0;

  aes_inport dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_key     (in_key),
    .core_ready (core_ready),
    .pass_data  (pass_data),
    .key_en     (key_en),
    .text_en    (text_en),
    .in_busy    (in_busy),
    .in_ovr     (in_ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pops one expected word per enabled cycle and insists the four words are contiguous.
  always @(negedge clk) begin
    if (rst) begin
      if (key_en && text_en) begin
        checks++;
        errors++;
        $display("[TB] FAIL enables_exclusive key_en=%0b text_en=%0b required one-hot", key_en, text_en);
      end
      if (key_en || text_en) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_word got %h key_en=%0b, none expected", pass_data, key_en);
          expect_cont = 1'b0;
        end else begin
          exp_t e;
          e = q.pop_front();
          if (pass_data !== e.data || key_en !== e.key || text_en !== ~e.key || in_busy !== ~e.last) begin
            errors++;
            $display("[TB] FAIL burst_word got data=%h key_en=%0b text_en=%0b busy=%0b, required data=%h key_en=%0b text_en=%0b busy=%0b",
                     pass_data, key_en, text_en, in_busy, e.data, e.key, ~e.key, ~e.last);
          end
          expect_cont = ~e.last;
        end
      end else if (expect_cont) begin
        checks++;
        errors++;
        $display("[TB] FAIL burst_gap no enable mid-burst, required contiguous words");
        expect_cont = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic k);
    in_data  = b;
    in_key   = k;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Bytes are base+0..base+15; in_key flips to ~key from byte toggle_at onward.
  task automatic send_block(input logic [7:0] base, input logic key, input int toggle_at,
                            input logic chk_ovr_clear);
    for (int w = 0; w < 4; w++) begin
      exp_t e;
      logic [7:0] b0;
      b0 = base + 8'(4 * w);
      e.data = {b0, b0 + 8'd1, b0 + 8'd2, b0 + 8'd3};
      e.key  = key;
      e.last = (w == 3);
      q.push_back(e);
    end
    for (int i = 0; i < 16; i++) begin
      send_byte(base + 8'(i), (i < toggle_at) ? key : ~key);
      if (chk_ovr_clear && i == 0) begin
        checks++;
        if (in_ovr !== 1'b0) begin
          errors++;
          $display("[TB] FAIL ovr_clear in_ovr=%0b required 0", in_ovr);
        end
      end
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((q.size() != 0 || key_en || text_en) && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0 || key_en || text_en) begin
      errors++;
      $display("[TB] FAIL %s_drain %0d words outstanding, required 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic test_reset();
    rst        = 1'b0;
    in_data    = 8'h00;
    in_valid   = 1'b0;
    in_key     = 1'b0;
    core_ready = 1'b0;
    #1;
    checks++;
    if (pass_data !== 32'd0 || key_en !== 1'b0 || text_en !== 1'b0 || in_busy !== 1'b0 || in_ovr !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs data=%h key=%0b text=%0b busy=%0b ovr=%0b required all 0",
               pass_data, key_en, text_en, in_busy, in_ovr);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_key_block();
    core_ready = 1'b1;
    send_block(8'h00, 1'b1, 16, 1'b0);
    wait_drain("key_block");
    repeat (2) @(negedge clk);
    checks++;
    if (pass_data !== 32'h0C0D0E0F) begin
      errors++;
      $display("[TB] FAIL hold_last got %h required 0c0d0e0f", pass_data);
    end
  endtask

  task automatic test_plain_stall();
    core_ready = 1'b0;
    send_block(8'hF0, 1'b0, 16, 1'b0);
    for (int c = 0; c < 20; c++) begin
      checks++;
      if (in_busy !== 1'b1 || key_en !== 1'b0 || text_en !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stall_cycle%0d busy=%0b key=%0b text=%0b required 1/0/0", c, in_busy, key_en, text_en);
      end
      @(negedge clk);
    end
    core_ready = 1'b1;
    wait_drain("plain_stall");
  endtask

  task automatic test_overrun();
    core_ready = 1'b0;
    send_block(8'h40, 1'b0, 16, 1'b0);
    send_byte(8'hAA, 1'b0);
    checks++;
    if (in_ovr !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ovr_set in_ovr=%0b required 1", in_ovr);
    end
    core_ready = 1'b1;
    wait_drain("overrun");
    checks++;
    if (in_ovr !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ovr_sticky in_ovr=%0b required 1", in_ovr);
    end
    send_block(8'h50, 1'b1, 16, 1'b1);
    wait_drain("after_overrun");
  endtask

  task automatic test_reset_mid();
    core_ready = 1'b1;
    for (int i = 0; i < 7; i++) send_byte(8'hC0 + 8'(i), 1'b1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send_block(8'h10, 1'b0, 16, 1'b0);
    wait_drain("reset_mid");
  endtask

  task automatic test_key_toggle();
    core_ready = 1'b1;
    send_block(8'h60, 1'b1, 5, 1'b0);
    wait_drain("key_toggle");
  endtask

  task automatic test_ready_drop();
    core_ready = 1'b0;
    send_block(8'h80, 1'b1, 16, 1'b0);
    core_ready = 1'b1;
    @(negedge clk);
    core_ready = 1'b0;
    wait_drain("ready_drop");
  endtask

  initial begin
    test_reset();
    test_key_block();
    test_plain_stall();
    test_overrun();
    test_reset_mid();
    test_key_toggle();
    test_ready_drop();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
